// File: rtl/interface_pkg.sv
// interface_pkg: memory request/response structs and arbiter state shared by caches, arbiter and Memory
package interface_pkg;
    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  wstrb;
    } Memory_Request;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } Memory_Response;

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} arb_state_t;
endpackage

// File: rtl/memory_pkg.sv
// memory_pkg: Memory timing parameters
package memory_pkg;
    localparam int DELAY = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side buses of the shared-memory arbiter
interface mem_arbiter_if
    import interface_pkg::*;
#(
    parameter int NUM_PORTS = 2
);
    Memory_Request                  req_i  [NUM_PORTS];
    Memory_Response                 resp_o [NUM_PORTS];
    Memory_Request                  mem_req_o;
    Memory_Response                 mem_resp_i;
    logic [$clog2(NUM_PORTS)-1:0]   grant_o;
    logic                           busy_o;

    modport slave (input req_i, mem_resp_i, output resp_o, mem_req_o, grant_o, busy_o);
    modport master (output req_i, mem_resp_i, input resp_o, mem_req_o, grant_o, busy_o);
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, searching from last_grant+1 and wrapping
module rr_picker #(
    parameter int NUM_PORTS = 2,
    localparam int GW = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_vec,
    input  logic [GW-1:0]        last_grant,
    output logic                 any,
    output logic [GW-1:0]        winner
);
    logic [GW-1:0] idx;

    // Scan farthest-first so the closest requester after last_grant overwrites last
    always_comb begin
        winner = last_grant;
        idx = last_grant;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = GW'((int'(last_grant) + i) % NUM_PORTS);
            winner = req_vec[idx] ? idx : winner;
        end
    end

    assign any = |req_vec;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one Memory between NUM_PORTS requesters
module mem_arbiter
    import interface_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input logic        clk,
    input logic        rst,
    mem_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_PORTS);

    arb_state_t          state, state_n;
    Memory_Request       mreq;
    logic [GW-1:0]       grant;
    logic [31:0]         rdata;
    logic [NUM_PORTS-1:0] vld;
    logic                any;
    logic [GW-1:0]       winner;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_vld
        assign vld[k] = bus.req_i[k].valid;
    end

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req_vec(vld),
        .last_grant(grant),
        .any(any),
        .winner(winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE    ? (any ? ISSUE : IDLE) :
                  state == ISSUE   ? (bus.mem_resp_i.valid ? RESPOND : ISSUE) :
                                     IDLE;
    end

    // Request stays valid on the cycle the response is seen so Memory clears its sticky response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mreq  <= '0;
            grant <= GW'(NUM_PORTS - 1);
            rdata <= '0;
        end else if (state == IDLE && any) begin
            mreq       <= bus.req_i[winner];
            mreq.valid <= 1'b1;
            grant      <= winner;
        end else if (state == ISSUE && bus.mem_resp_i.valid) begin
            mreq.valid <= 1'b0;
            rdata      <= bus.mem_resp_i.data;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            bus.resp_o[i] = '{valid: state == RESPOND && grant == GW'(i), data: rdata};
        bus.mem_req_o = mreq;
        bus.grant_o   = grant;
        bus.busy_o    = state != IDLE;
    end
endmodule
